// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states
// and the default datapath width.
package hilo_muldiv_unit_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] MDU_NOP   = 3'b000;
    localparam logic [2:0] MDU_MULT  = 3'b001;
    localparam logic [2:0] MDU_MULTU = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b011;
    localparam logic [2:0] MDU_DIVU  = 3'b100;
    localparam logic [2:0] MDU_MTHI  = 3'b101;
    localparam logic [2:0] MDU_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_ADJ  = 2'd3
    } mdu_state_e;

    // Ops that occupy the unit for the full iterative latency.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline and the mul/div unit.
interface hilo_muldiv_unit_if
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             cancel;
    logic             mf_read;
    logic             busy;
    logic             done;
    logic             stall_req;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, rs_val, rt_val, cancel, mf_read,
        input  busy, done, stall_req, hi_out, lo_out
    );

    modport slave (
        input  start, op, rs_val, rt_val, cancel, mf_read,
        output busy, done, stall_req, hi_out, lo_out
    );
endinterface

// File: rtl/hilo_muldiv_unit_datapath.sv
// Shift-add multiplier / restoring divider on magnitudes, with sign fix-up of the
// final accumulator. Sequencing comes entirely from the owning FSM.
module muldiv_datapath
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   rs_raw;
    logic               div_mode;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;

    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;

    assign rs_neg = is_signed & rs[WIDTH-1];
    assign rt_neg = is_signed & rt[WIDTH-1];
    assign rs_mag = rs_neg ? -rs : rs;
    assign rt_mag = rt_neg ? -rt : rt;

    // Multiply: acc = {partial, multiplier}; add multiplicand into the top, shift right.
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign mul_next = {add_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; shift left and trial-subtract.
    logic [WIDTH:0]     top, diff;
    logic               fits;
    logic [2*WIDTH-1:0] div_next;
    assign top      = acc[2*WIDTH-1:WIDTH-1];
    assign diff     = top - {1'b0, mcand};
    assign fits     = ~diff[WIDTH];
    assign div_next = {(fits ? diff[WIDTH-1:0] : top[WIDTH-1:0]), acc[WIDTH-2:0], fits};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            mcand    <= '0;
            rs_raw   <= '0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            acc      <= {{WIDTH{1'b0}}, (is_div ? rs_mag : rt_mag)};
            mcand    <= is_div ? rt_mag : rs_mag;
            rs_raw   <= rs;
            div_mode <= is_div;
            neg_q    <= rs_neg ^ rt_neg;
            neg_r    <= rs_neg;
            div_zero <= is_div && (rt == '0);
        end else if (step) begin
            acc <= div_mode ? div_next : mul_next;
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem;
    assign prod_fix = neg_q ? -acc : acc;
    assign quo      = acc[WIDTH-1:0];
    assign rem      = acc[2*WIDTH-1:WIDTH];

    // Divide-by-zero reports all-ones quotient and the untouched dividend.
    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (div_mode) begin
            if (div_zero) begin
                res_hi = rs_raw;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -rem : rem;
                res_lo = neg_q ? -quo : quo;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative mul/div unit owning the architectural HI/LO registers; raises a stall
// toward the hazard unit while an MFHI/MFLO would observe an in-flight result.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    hilo_muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(ITER);

    mdu_state_e       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hi, lo;
    logic             busy, done;
    logic [WIDTH-1:0] dp_hi, dp_lo;
    logic             accept, load, step;

    assign accept = (state == S_IDLE) && bus.start && !bus.cancel;
    assign load   = accept && is_long_op(bus.op);
    assign step   = (state == S_MUL) || (state == S_DIV);

    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .is_div    (is_div_op(bus.op)),
        .is_signed (is_signed_op(bus.op)),
        .rs        (bus.rs_val),
        .rt        (bus.rt_val),
        .res_hi    (dp_hi),
        .res_lo    (dp_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (bus.op)
                            MDU_MULT, MDU_MULTU: begin
                                state <= S_MUL;
                                count <= '0;
                                busy  <= 1'b1;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                state <= S_DIV;
                                count <= '0;
                                busy  <= 1'b1;
                            end
                            MDU_MTHI: hi <= bus.rs_val;
                            MDU_MTLO: lo <= bus.rs_val;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (bus.cancel) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (count == CW'(ITER - 1)) begin
                        state <= S_ADJ;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_ADJ: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    if (!bus.cancel) begin
                        hi   <= dp_hi;
                        lo   <= dp_lo;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.hi_out    = hi;
    assign bus.lo_out    = lo;
    assign bus.stall_req = bus.mf_read & (busy | (bus.start & is_long_op(bus.op)));

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed plus random checks of the HI/LO mul/div unit against a plain-arithmetic model.
module tb_hilo_muldiv_unit;
    import hilo_muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hilo_muldiv_unit_if #(.WIDTH(32)) bus();

    hilo_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {hi, lo} straight from the arithmetic definition of each op.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = '0;
        case (op)
            MDU_MULTU: res = ua * ub;
            MDU_MULT:  res = sa * sb;
            MDU_DIV, MDU_DIVU: begin
                if (b == 32'b0) res = {a, 32'hFFFF_FFFF};
                else if (op == MDU_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        tick();
        bus.start  = 1'b0;
        bus.op     = MDU_NOP;
    endtask

    // Runs one long op to completion, checking latency, done pulse, stall and result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic mf);
        logic [63:0] exp;
        int bcyc;
        int stall_bad;
        exp = model(op, a, b);
        bus.mf_read = mf;
        issue(op, a, b);
        bcyc = 0;
        stall_bad = 0;
        while (bus.busy === 1'b1 && bcyc < 40) begin
            if (bus.stall_req !== mf) stall_bad++;
            if (bus.done !== 1'b0) stall_bad++;
            bcyc++;
            tick();
        end
        bus.mf_read = 1'b0;
        chk({tag, " busy_cycles"}, 64'(bcyc), 64'd33);
        chk({tag, " stall/done_during_busy"}, 64'(stall_bad), 64'd0);
        chk({tag, " done"}, 64'(bus.done), 64'd1);
        chk({tag, " hilo"}, {bus.hi_out, bus.lo_out}, exp);
        tick();
        chk({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        issue(MDU_MTHI, h, 32'h0);
        issue(MDU_MTLO, l, 32'h0);
    endtask

    initial begin
        logic [63:0] exp;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          dcnt;

        reset = 1'b1;
        bus.start = 1'b0; bus.op = MDU_NOP; bus.rs_val = '0; bus.rt_val = '0;
        bus.cancel = 1'b0; bus.mf_read = 1'b0;
        tick(); tick();
        chk("reset hilo", {bus.hi_out, bus.lo_out}, 64'h0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle stall", 64'(bus.stall_req), 64'd0);

        run_op("multu_ffff_x2", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
        chk("multu const", {bus.hi_out, bus.lo_out}, 64'h0000_0001_FFFF_FFFE);
        run_op("mult_m3_x5", MDU_MULT, -32'sd3, 32'd5, 1'b0);
        chk("mult const", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("div_m7_2", MDU_DIV, -32'sd7, 32'd2, 1'b1);
        chk("div const", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_by0", MDU_DIVU, 32'd7, 32'd0, 1'b0);
        chk("divu0 const", {bus.hi_out, bus.lo_out}, 64'h0000_0007_FFFF_FFFF);
        run_op("div_min_m1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div ovf const", {bus.hi_out, bus.lo_out}, 64'h0000_0000_8000_0000);
        run_op("div_neg_by0", MDU_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0);

        // MTHI lands on the next edge with no done pulse
        set_hilo(32'h5, 32'h6);
        issue(MDU_MTHI, 32'h1234, 32'h0);
        chk("mthi hi", 64'(bus.hi_out), 64'h1234);
        chk("mthi done", 64'(bus.done), 64'd0);
        bus.cancel = 1'b1;
        issue(MDU_MTLO, 32'hDEAD, 32'h0);
        bus.cancel = 1'b0;
        chk("mtlo cancel lo", 64'(bus.lo_out), 64'h6);

        // stall_req in IDLE follows start of a long op; cancel drops the op itself
        bus.mf_read = 1'b1; bus.cancel = 1'b1;
        bus.start = 1'b1; bus.op = MDU_DIV; bus.rs_val = 32'd9; bus.rt_val = 32'd3;
        #1;
        chk("stall idle div", 64'(bus.stall_req), 64'd1);
        bus.op = MDU_MTHI;
        #1;
        chk("stall idle mthi", 64'(bus.stall_req), 64'd0);
        bus.op = MDU_DIV;
        tick();
        bus.start = 1'b0; bus.cancel = 1'b0; bus.mf_read = 1'b0; bus.op = MDU_NOP;
        chk("start+cancel dropped", 64'(bus.busy), 64'd0);

        // cancel mid-flight
        set_hilo(32'hA, 32'hB);
        issue(MDU_MULT, 32'd100, 32'd200);
        for (int i = 0; i < 9; i++) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("cancel busy", 64'(bus.busy), 64'd0);
        chk("cancel hilo", {bus.hi_out, bus.lo_out}, 64'h0000_000A_0000_000B);
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done) dcnt++;
            tick();
        end
        chk("cancel no done", 64'(dcnt), 64'd0);
        chk("cancel hilo later", {bus.hi_out, bus.lo_out}, 64'h0000_000A_0000_000B);

        // reset mid-flight
        issue(MDU_DIVU, 32'd1000, 32'd7);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset mid busy", 64'(bus.busy), 64'd0);
        chk("reset mid hilo", {bus.hi_out, bus.lo_out}, 64'h0);
        tick();

        // cancel landing exactly in ADJ
        set_hilo(32'hC, 32'hD);
        issue(MDU_MULTU, 32'd3, 32'd4);
        for (int i = 0; i < 32; i++) tick();
        chk("adj still busy", 64'(bus.busy), 64'd1);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("adj cancel busy", 64'(bus.busy), 64'd0);
        chk("adj cancel done", 64'(bus.done), 64'd0);
        chk("adj cancel hilo", {bus.hi_out, bus.lo_out}, 64'h0000_000C_0000_000D);

        // start while busy is ignored
        exp = model(MDU_MULT, 32'h1234_5678, 32'hFEDC_BA98);
        issue(MDU_MULT, 32'h1234_5678, 32'hFEDC_BA98);
        for (int i = 0; i < 5; i++) tick();
        bus.start = 1'b1; bus.op = MDU_DIVU; bus.rs_val = 32'd77; bus.rt_val = 32'd5;
        tick(); tick();
        bus.start = 1'b0; bus.op = MDU_NOP;
        dcnt = 0;
        while (bus.busy === 1'b1 && dcnt < 40) begin
            dcnt++;
            tick();
        end
        chk("start_busy latency", 64'(dcnt), 64'd26);
        chk("start_busy done", 64'(bus.done), 64'd1);
        chk("start_busy hilo", {bus.hi_out, bus.lo_out}, exp);
        tick();
        chk("start_busy idle", 64'(bus.busy), 64'd0);

        // random long ops
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom();
            rb  = $urandom();
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op($sformatf("rand%0d op%0d", n, rop), rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
